// File: rtl/impulse_pkg.sv
// impulse_pkg: definitions shared by the impulse MAC and the memory controller.
// Holds the impulse-word field layout, the MAC frame FSM encoding and the
// 16-bit output saturation helper.
package impulse_pkg;

    localparam int TOP_OFF_MSB = 15;
    localparam int TOP_OFF_LSB = 13;
    localparam int BOT_OFF_MSB = 12;
    localparam int BOT_OFF_LSB = 9;
    localparam int NEG_BIT     = 8;
    localparam int MULT_MSB    = 7;
    localparam int MULT_LSB    = 0;

    // signed 16-bit sample times zero-extended 8-bit multiplier
    localparam int PROD_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUTPUT
    } mac_state_t;

    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/impulse_mac_if.sv
// impulse_mac_if: (impulse word, history sample) stream from the memory
// controller into the impulse MAC, valid/ready handshake.
interface impulse_mac_if;
    logic        tap_valid;
    logic        tap_ready;
    logic [15:0] impulse_word;
    logic [15:0] sample_word;

    modport master (
        output tap_valid,
        output impulse_word,
        output sample_word,
        input  tap_ready
    );

    modport slave (
        input  tap_valid,
        input  impulse_word,
        input  sample_word,
        output tap_ready
    );
endinterface

// File: rtl/impulse_mac_sat_accumulator.sv
// impulse_mac_sat_accumulator: second pipeline stage of the impulse MAC.
// Adds a signed product into the frame accumulator, pegging at the most
// positive / most negative value instead of wrapping.
module impulse_mac_sat_accumulator #(
    parameter int ACC_W  = 32,
    parameter int PROD_W = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  acc
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_sat;

    // One guard bit catches overflow; clamp toward the sign of the true sum
    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        sum_sat = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator register: clear at frame output wins over a new product
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum_sat;
        end
    end

endmodule

// File: rtl/impulse_mac.sv
// impulse_mac: convolution-reverb multiply-accumulate. Accumulates signed
// sample * impulse-coefficient products over one adc_clock frame and emits
// one saturated 16-bit wet sample per frame.
// Optional build macro IMPULSE_MAC_DRY_MIX_EN adds a dry_sample input that is
// mixed into the output sample.
module impulse_mac
    import impulse_pkg::*;
#(
    parameter int MAX_TAPS  = 500,
    parameter int OUT_SHIFT = 8,
    parameter int ACC_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adc_clock,
    impulse_mac_if.slave       tap,
`ifdef IMPULSE_MAC_DRY_MIX_EN
    input  logic signed [15:0] dry_sample,
`endif
    output logic signed [15:0] data_out,
    output logic               out_valid,
    output logic [10:0]        tap_count,
    output logic               tap_overflow
);

    localparam logic [10:0] TAP_LIMIT = 11'(MAX_TAPS);

    mac_state_t state, next_state;
    logic drain_second;
    logic adc_prev, frame_edge;
    logic tap_ready_c, accept, mult_en, out_load, clear_frame;
    logic overflow_sticky;
    logic [7:0] mult;
    logic signed [PROD_W-1:0] samp_ext, mult_ext, raw_prod, s1_prod;
    logic s1_valid;
    logic signed [ACC_W-1:0] acc, acc_shifted;
    logic signed [15:0] wet_sat, out_value;
    logic unused_offsets;

    assign frame_edge    = adc_clock & ~adc_prev;
    assign tap.tap_ready = tap_ready_c;
    assign accept        = tap.tap_valid & tap_ready_c;
    assign mult_en       = accept & (tap_count < TAP_LIMIT);

    assign mult     = tap.impulse_word[MULT_MSB:MULT_LSB];
    assign samp_ext = {{(PROD_W-16){tap.sample_word[15]}}, tap.sample_word};
    assign mult_ext = {{(PROD_W-8){1'b0}}, mult};
    assign raw_prod = samp_ext * mult_ext;

    // The offset fields steer the memory controller and carry no meaning here
    assign unused_offsets = ^tap.impulse_word[TOP_OFF_MSB:BOT_OFF_LSB];

    // State register, adc_clock history for edge detect, and DRAIN cycle marker
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            adc_prev     <= 1'b0;
            drain_second <= 1'b0;
        end else begin
            state        <= next_state;
            adc_prev     <= adc_clock;
            drain_second <= (state == ST_DRAIN) & ~drain_second;
        end
    end

    // Frame sequencing; edges outside ACCUM/IDLE are ignored by construction
    always_comb begin
        next_state  = state;
        tap_ready_c = 1'b0;
        out_load    = 1'b0;
        clear_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_edge) next_state = ST_ACCUM;
            end
            ST_ACCUM: begin
                tap_ready_c = ~frame_edge;
                if (frame_edge) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_second) begin
                    out_load   = 1'b1;
                    next_state = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                clear_frame = 1'b1;
                next_state  = ST_ACCUM;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Stage 1: register the signed product of an accepted in-limit tap
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= mult_en;
            if (mult_en) begin
                s1_prod <= tap.impulse_word[NEG_BIT] ? -raw_prod : raw_prod;
            end
        end
    end

    // Tap counting; taps past the limit are swallowed and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_count       <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear_frame) begin
            tap_count       <= '0;
            overflow_sticky <= 1'b0;
        end else if (accept) begin
            if (tap_count < TAP_LIMIT) begin
                tap_count <= tap_count + 11'd1;
            end else begin
                overflow_sticky <= 1'b1;
            end
        end
    end

    impulse_mac_sat_accumulator #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_frame),
        .enable(s1_valid),
        .prod  (s1_prod),
        .acc   (acc)
    );

    assign acc_shifted = acc >>> OUT_SHIFT;
    assign wet_sat     = sat16(64'(acc_shifted));

`ifdef IMPULSE_MAC_DRY_MIX_EN
    logic signed [15:0] dry_hold;
    logic signed [17:0] mix_sum;

    // Capture the dry sample at the edge that closes the frame being accumulated
    always_ff @(posedge clk) begin
        if (rst) begin
            dry_hold <= '0;
        end else if ((state == ST_ACCUM) && frame_edge) begin
            dry_hold <= dry_sample;
        end
    end

    assign mix_sum   = {{2{wet_sat[15]}}, wet_sat} + {{2{dry_hold[15]}}, dry_hold};
    assign out_value = sat16(64'(mix_sum));
`else
    assign out_value = wet_sat;
`endif

    // Output registers load on the last DRAIN cycle so they are valid in OUTPUT
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= '0;
            out_valid    <= 1'b0;
            tap_overflow <= 1'b0;
        end else begin
            out_valid    <= out_load;
            tap_overflow <= out_load & overflow_sticky;
            if (out_load) begin
                data_out <= out_value;
            end
        end
    end

endmodule

// File: tb/tb_impulse_mac.sv
// tb_impulse_mac: randomized and directed stimulus for impulse_mac, checked
// against a cycle-level behavioural model of frames, taps and saturation.
module tb_impulse_mac;

    localparam int MAX_TAPS  = 500;
    localparam int OUT_SHIFT = 8;

    typedef struct {
        logic [15:0] iw;
        logic [15:0] sw;
    } tap_t;

    logic        clk;
    logic        rst;
    logic        adc_clock;
    logic [15:0] data_out;
    logic        out_valid;
    logic [10:0] tap_count;
    logic        tap_overflow;
`ifdef IMPULSE_MAC_DRY_MIX_EN
    logic [15:0] dry_sample;
`endif

    impulse_mac_if tap ();

    impulse_mac #(
        .MAX_TAPS (MAX_TAPS),
        .OUT_SHIFT(OUT_SHIFT),
        .ACC_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_clock   (adc_clock),
        .tap         (tap),
`ifdef IMPULSE_MAC_DRY_MIX_EN
        .dry_sample  (dry_sample),
`endif
        .data_out    (data_out),
        .out_valid   (out_valid),
        .tap_count   (tap_count),
        .tap_overflow(tap_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit     m_active;
    bit     m_prev;
    int     m_block;
    int     m_out_at;
    longint m_acc;
    int     m_count;
    bit     m_ovf;
    logic [15:0] exp_hold;
    int     cyc = 0;

    // observed output pulses, for the directed scenarios
    int          n_outs = 0;
    logic [15:0] last_data;
    logic        last_ovf;
    logic [10:0] last_count;

    tap_t tap_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic longint clampAcc(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [15:0] wetOf(input longint a);
        longint w;
        w = a >>> OUT_SHIFT;
        if (w > 32767) return 16'h7FFF;
        if (w < -32768) return 16'h8000;
        return 16'(w);
    endfunction

    task automatic pushTap(input int sample, input int mult, input bit neg);
        tap_t t;
        t.sw = 16'(sample);
        t.iw = {3'($urandom), 4'($urandom), neg, 8'(mult)};
        tap_q.push_back(t);
    endtask

    task automatic doReset();
        rst = 1'b1;
        adc_clock = 1'b0;
        tap.tap_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_tap_ready", 32'(tap.tap_ready), 32'd0);
        checkOutput("rst_tap_count", 32'(tap_count), 32'd0);
        checkOutput("rst_tap_overflow", 32'(tap_overflow), 32'd0);
        rst = 1'b0;
        m_active = 1'b0;
        m_prev   = 1'b0;
        m_block  = 0;
        m_out_at = -1;
        m_acc    = 0;
        m_count  = 0;
        m_ovf    = 1'b0;
        exp_hold = 16'h0000;
    endtask

    // One clk cycle: drive inputs, compare all outputs to the model, advance
    task automatic applyStimulus(input bit adc, input bit valid, input logic [15:0] iw,
                                 input logic [15:0] sw, output bit accepted);
        bit edge_now, in_accum, exp_ready, is_out;
        int s, m;
        longint p;
        adc_clock        = adc;
        tap.tap_valid    = valid;
        tap.impulse_word = iw;
        tap.sample_word  = sw;
        edge_now  = adc && !m_prev;
        in_accum  = m_active && (m_block == 0);
        exp_ready = in_accum && !edge_now;
        is_out    = (cyc == m_out_at);
        #1;
        checkOutput("tap_ready", 32'(tap.tap_ready), 32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(is_out));
        checkOutput("tap_count", 32'(tap_count), 32'(m_count));
        checkOutput("tap_overflow", 32'(tap_overflow), 32'(is_out && m_ovf));
        if (out_valid) begin
            n_outs++;
            last_data  = data_out;
            last_ovf   = tap_overflow;
            last_count = tap_count;
        end
        if (is_out) begin
            exp_hold = wetOf(m_acc);
            m_acc    = 0;
            m_count  = 0;
            m_ovf    = 1'b0;
        end
        checkOutput("data_out", 32'(data_out), 32'(exp_hold));

        accepted = exp_ready && valid;
        if (accepted) begin
            if (m_count < MAX_TAPS) begin
                s = int'($signed(sw));
                m = int'(iw[7:0]);
                p = longint'(s) * longint'(m);
                if (iw[8]) p = -p;
                m_acc = clampAcc(m_acc + p);
                m_count++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_block > 0) m_block--;
        if (edge_now) begin
            if (!m_active) begin
                m_active = 1'b1;
            end else if (in_accum) begin
                m_block  = 3;
                m_out_at = cyc + 3;
            end
        end
        m_prev = adc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One adc_clock frame starting with its rising edge.
    // mode 0: queued taps, 1: random valid/data, 2: valid always high, 3: idle
    task automatic runFrame(input int min_len, input int mode);
        int i = 0;
        bit acc_b, v;
        logic [15:0] iw, sw;
        while ((i < min_len || (mode == 0 && tap_q.size() > 0)) && i < 4000) begin
            v = 1'b0;
            iw = 16'h0000;
            sw = 16'h0000;
            case (mode)
                0: if (tap_q.size() > 0) begin
                    v  = 1'b1;
                    iw = tap_q[0].iw;
                    sw = tap_q[0].sw;
                end
                1: begin
                    v  = 1'($urandom_range(0, 1));
                    iw = 16'($urandom);
                    sw = 16'($urandom);
                end
                2: begin
                    v  = 1'b1;
                    iw = 16'($urandom);
                    sw = 16'($urandom);
                end
                default: ;
            endcase
            applyStimulus(i < 2, v, iw, sw, acc_b);
            if (mode == 0 && acc_b) void'(tap_q.pop_front());
            i++;
        end
        if (i >= 4000) checkOutput("frame_bound", 32'd1, 32'd0);
    endtask

    int outs_before;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        adc_clock = 1'b0;
        tap.tap_valid = 1'b0;
        tap.impulse_word = 16'h0000;
        tap.sample_word = 16'h0000;
`ifdef IMPULSE_MAC_DRY_MIX_EN
        dry_sample = 16'h0000;
`endif
        doReset();

        // first edge only arms the block
        outs_before = n_outs;
        runFrame(6, 3);
        checkOutput("arm_no_out", 32'(n_outs - outs_before), 32'd0);

        // directed three-tap frame
        pushTap(1000, 128, 1'b0);
        pushTap(1000, 128, 1'b1);
        pushTap(-200, 255, 1'b0);
        runFrame(6, 0);
        outs_before = n_outs;
        runFrame(8, 3);
        checkOutput("dir_pulses", 32'(n_outs - outs_before), 32'd1);
        checkOutput("dir_data", 32'(last_data), 32'h0000FF38);

        // positive and negative saturation (accumulator would wrap otherwise)
        for (int k = 0; k < 300; k++) pushTap(32767, 255, 1'b0);
        runFrame(6, 0);
        runFrame(8, 3);
        checkOutput("sat_pos", 32'(last_data), 32'h00007FFF);
        for (int k = 0; k < 300; k++) pushTap(32767, 255, 1'b1);
        runFrame(6, 0);
        runFrame(8, 3);
        checkOutput("sat_neg", 32'(last_data), 32'h00008000);

        // tap limit
        for (int k = 0; k < MAX_TAPS + 2; k++) pushTap(256, 1, 1'b0);
        runFrame(6, 0);
        runFrame(8, 3);
        checkOutput("ovf_data", 32'(last_data), 32'(MAX_TAPS));
        checkOutput("ovf_flag", 32'(last_ovf), 32'd1);
        checkOutput("ovf_count", 32'(last_count), 32'(MAX_TAPS));
        pushTap(256, 1, 1'b0);
        pushTap(256, 1, 1'b0);
        runFrame(6, 0);
        runFrame(8, 3);
        checkOutput("ovf_next_data", 32'(last_data), 32'd2);
        checkOutput("ovf_next_flag", 32'(last_ovf), 32'd0);

        // backpressure: valid held high across edges
        repeat (4) runFrame($urandom_range(6, 30), 2);
        // random traffic
        repeat (10) runFrame($urandom_range(6, 40), 1);

        // reset in the middle of an accumulating frame
        for (int k = 0; k < 10; k++) pushTap(1234, 77, 1'b0);
        runFrame(14, 0);
        doReset();
        outs_before = n_outs;
        runFrame(8, 1);
        checkOutput("post_rst_no_out", 32'(n_outs - outs_before), 32'd0);
        runFrame(8, 3);
        checkOutput("post_rst_one_out", 32'(n_outs - outs_before), 32'd1);
        runFrame(8, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
